// File: rtl/ball_motion_engine_if.sv
// Bus between the pong display controller and the ball motion engine.
// The controller supplies the frame strobe and paddle flags; the engine returns ball position and score.
`timescale 1ns/1ps
interface ball_motion_engine_if;
  logic       frame_tick;
  logic       bounce_x;
  logic       bounce_y;
  logic       start;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [2:0] winner;
  logic       in_play;
  logic       goal_pulse;

  modport master (
    output frame_tick, bounce_x, bounce_y, start,
    input  ball_x, ball_y, p1_score, p2_score, winner, in_play, goal_pulse
  );

  modport slave (
    input  frame_tick, bounce_x, bounce_y, start,
    output ball_x, ball_y, p1_score, p2_score, winner, in_play, goal_pulse
  );
endinterface

// File: rtl/ball_motion_engine.sv
// Frame-rate ball physics and scoring for the pong display path.
// Updates once per rising edge of frame_tick; start is honoured on any cycle in IDLE/OVER.
`timescale 1ns/1ps
// state   | meaning
// S_IDLE  | after reset, ball at centre, waiting for start
// S_SERVE | ball at centre, counting frames before launch
// S_MOVE  | ball moving, walls/goals resolved each frame
// S_OVER  | match won, scores held until start
module ball_motion_engine #(
  parameter int X_INIT       = 320,
  parameter int Y_INIT       = 240,
  parameter int X_MIN        = 10,
  parameter int X_MAX        = 629,
  parameter int Y_MIN        = 15,
  parameter int Y_MAX        = 464,
  parameter int GOAL_TOP     = 200,
  parameter int GOAL_BOT     = 280,
  parameter int SPEED_X      = 2,
  parameter int SPEED_Y      = 1,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7
) (
  input logic               clk,
  input logic               reset,
  ball_motion_engine_if.slave bus
);

  localparam int CW = $clog2(SERVE_FRAMES + 1);
  localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
  localparam logic signed [10:0] YMIN_S = 11'(Y_MIN);
  localparam logic signed [10:0] YMAX_S = 11'(Y_MAX);
  localparam logic signed [10:0] SPD_X  = 11'(SPEED_X);
  localparam logic signed [10:0] SPD_Y  = 11'(SPEED_Y);

  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_MOVE, S_OVER} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_tick_q;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [9:0]      r_x, w_x_nxt;
  logic [8:0]      r_y, w_y_nxt;
  logic            r_dx, w_dx_nxt;
  logic            r_dy, w_dy_nxt;
  logic [3:0]      r_p1, w_p1_nxt;
  logic [3:0]      r_p2, w_p2_nxt;
  logic [2:0]      r_win, w_win_nxt;
  logic            r_goal, w_goal_nxt;

  logic            w_upd;
  logic            w_dx_eff;
  logic            w_dy_eff;
  logic            w_in_goal;
  logic            w_p1_pt;
  logic            w_p2_pt;
  logic signed [10:0] w_xpos, w_ypos, w_nx, w_ny;

  // r_dx: 1 = moving right, r_dy: 1 = moving down
  assign w_upd     = bus.frame_tick & ~r_tick_q;
  assign w_dx_eff  = r_dx ^ bus.bounce_x;
  assign w_dy_eff  = r_dy ^ bus.bounce_y;
  assign w_xpos    = {1'b0, r_x};
  assign w_ypos    = {2'b00, r_y};
  assign w_nx      = w_dx_eff ? (w_xpos + SPD_X) : (w_xpos - SPD_X);
  assign w_ny      = w_dy_eff ? (w_ypos + SPD_Y) : (w_ypos - SPD_Y);
  assign w_in_goal = (r_y >= 9'(GOAL_TOP)) && (r_y <= 9'(GOAL_BOT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_tick_q <= 1'b0;
      r_cnt    <= '0;
      r_x      <= 10'(X_INIT);
      r_y      <= 9'(Y_INIT);
      r_dx     <= 1'b1;
      r_dy     <= 1'b1;
      r_p1     <= 4'd0;
      r_p2     <= 4'd0;
      r_win    <= 3'd0;
      r_goal   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tick_q <= bus.frame_tick;
      r_cnt    <= w_cnt_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_dx     <= w_dx_nxt;
      r_dy     <= w_dy_nxt;
      r_p1     <= w_p1_nxt;
      r_p2     <= w_p2_nxt;
      r_win    <= w_win_nxt;
      r_goal   <= w_goal_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_dx_nxt    = r_dx;
    w_dy_nxt    = r_dy;
    w_p1_nxt    = r_p1;
    w_p2_nxt    = r_p2;
    w_win_nxt   = r_win;
    w_goal_nxt  = 1'b0;
    w_p1_pt     = 1'b0;
    w_p2_pt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_SERVE;
          w_cnt_nxt   = '0;
        end
      end
      S_SERVE: begin
        if (w_upd) begin
          if (r_cnt == CW'(SERVE_FRAMES - 1)) w_state_nxt = S_MOVE;
          else                               w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      S_MOVE: begin
        if (w_upd) begin
          w_dx_nxt = w_dx_eff;
          w_dy_nxt = w_dy_eff;
          w_x_nxt  = w_nx[9:0];
          w_y_nxt  = w_ny[8:0];
          if (w_ny <= YMIN_S) begin
            w_y_nxt  = 9'(Y_MIN);
            w_dy_nxt = 1'b1;
          end else if (w_ny >= YMAX_S) begin
            w_y_nxt  = 9'(Y_MAX);
            w_dy_nxt = 1'b0;
          end
          // goal test uses the pre-move y so a wall clamp cannot push the ball out of the goal
          if (w_nx <= XMIN_S) begin
            if (w_in_goal) w_p2_pt = 1'b1;
            else begin
              w_x_nxt  = 10'(X_MIN);
              w_dx_nxt = 1'b1;
            end
          end else if (w_nx >= XMAX_S) begin
            if (w_in_goal) w_p1_pt = 1'b1;
            else begin
              w_x_nxt  = 10'(X_MAX);
              w_dx_nxt = 1'b0;
            end
          end
          if (w_p1_pt || w_p2_pt) begin
            w_goal_nxt = 1'b1;
            w_x_nxt    = 10'(X_INIT);
            w_y_nxt    = 9'(Y_INIT);
            w_dy_nxt   = 1'b1;
            w_cnt_nxt  = '0;
            if (w_p1_pt) begin
              w_p1_nxt    = (r_p1 >= 4'(WIN_SCORE)) ? 4'(WIN_SCORE) : r_p1 + 4'd1;
              w_win_nxt   = 3'd1;
              w_dx_nxt    = 1'b1;
              w_state_nxt = (w_p1_nxt == 4'(WIN_SCORE)) ? S_OVER : S_SERVE;
            end else begin
              w_p2_nxt    = (r_p2 >= 4'(WIN_SCORE)) ? 4'(WIN_SCORE) : r_p2 + 4'd1;
              w_win_nxt   = 3'd2;
              w_dx_nxt    = 1'b0;
              w_state_nxt = (w_p2_nxt == 4'(WIN_SCORE)) ? S_OVER : S_SERVE;
            end
          end
        end
      end
      S_OVER: begin
        if (bus.start) begin
          w_p1_nxt    = 4'd0;
          w_p2_nxt    = 4'd0;
          w_win_nxt   = 3'd0;
          w_dx_nxt    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SERVE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.ball_x     = r_x;
  assign bus.ball_y     = r_y;
  assign bus.p1_score   = r_p1;
  assign bus.p2_score   = r_p2;
  assign bus.winner     = r_win;
  assign bus.in_play    = (r_state == S_MOVE);
  assign bus.goal_pulse = r_goal;

endmodule

// File: doc/ball_motion_engine.md
Name: ball_motion_engine

Overview:
- Frame-rate ball physics and scoring stage for the pong display path.
- Sits directly upstream of the VGA controller: it produces the ball centre coordinates and the round winner code that the controller draws and shows on the seven-segment decoder.
- It consumes the controller's per-frame paddle-collision flags and the frame-end strobe.
- It replaces the software ball update, so ball motion no longer depends on processor timing.

Parameters:
- X_INIT, 320, serve x position (centre)
- Y_INIT, 240, serve y position
- X_MIN, 10, leftmost legal ball centre x (ball half-width)
- X_MAX, 629, rightmost legal ball centre x
- Y_MIN, 15, topmost legal ball centre y (ball half-height)
- Y_MAX, 464, bottommost legal ball centre y
- GOAL_TOP, 200, goal segment top y, inclusive
- GOAL_BOT, 280, goal segment bottom y, inclusive
- SPEED_X, 2, pixels per frame in x
- SPEED_Y, 1, pixels per frame in y
- SERVE_FRAMES, 60, frames held at centre before launch
- WIN_SCORE, 7, points needed to end the match

Ports:
- clk, input, 1, 100 MHz system clock; the only clock
- reset, input, 1, asynchronous, active-low reset
- frame_tick, input, 1, screenEnd from the timing generator; multi-cycle high in the clk domain; rising edge detected internally
- bounce_x, input, 1, paddle hit requiring x reflection; sampled on the update cycle
- bounce_y, input, 1, paddle hit requiring y reflection; sampled on the update cycle
- start, input, 1, level; launches play from IDLE or OVER
- ball_x, output, 10, ball centre x
- ball_y, output, 9, ball centre y
- p1_score, output, 4, player 1 points
- p2_score, output, 4, player 2 points
- winner, output, 3, 0 = none, 1 = player 1 won the last point or match, 2 = player 2
- in_play, output, 1, high only in MOVE
- goal_pulse, output, 1, one clk cycle high on the update that scores

Behaviour:
- Reset (async, reset=0) values:
  - ball_x=X_INIT, ball_y=Y_INIT
  - scores=0, winner=0, in_play=0, goal_pulse=0
  - dir_x=right, dir_y=down
  - state=IDLE, serve counter=0, edge-detect register=0
- Update strobe:
  - upd = frame_tick & ~frame_tick_q, registered at clk.
  - All state and position changes occur only on an upd cycle, except start handling in IDLE/OVER.
  - Outputs change 1 clk after the edge.
- States:
  - IDLE: ball held at centre. start=1 → SERVE, counter cleared.
  - SERVE: ball held at centre; counter increments on each upd. The upd on which the counter equals SERVE_FRAMES-1 → MOVE.
  - MOVE: per upd, in this order:
    1. bounce_x toggles dir_x; bounce_y toggles dir_y.
    2. Compute nx = ball_x ± SPEED_X and ny = ball_y ± SPEED_Y in 11-bit signed arithmetic (no unsigned wrap).
    3. Top/bottom walls: ny ≤ Y_MIN → ball_y=Y_MIN, dir_y=down. ny ≥ Y_MAX → ball_y=Y_MAX, dir_y=up.
    4. Left edge, nx ≤ X_MIN:
       - current ball_y within [GOAL_TOP, GOAL_BOT] → player 2 scores.
       - otherwise ball_x=X_MIN, dir_x=right.
    5. Right edge, nx ≥ X_MAX:
       - current ball_y within the goal range → player 1 scores.
       - otherwise ball_x=X_MAX, dir_x=left.
  - Scoring, on the same upd:
    - Increment the scorer's count, saturating at WIN_SCORE.
    - winner = scorer; goal_pulse=1 for that cycle.
    - Ball returns to X_INIT/Y_INIT.
    - Serve direction dir_x points toward the player who conceded; dir_y=down.
    - → OVER if the new score equals WIN_SCORE, else → SERVE (counter cleared).
  - OVER:
    - Ball at centre; winner and scores held.
    - start=1 → scores cleared, winner=0, dir_x=right → SERVE.
- Boundary rules:
  - A bounce_x that turns the ball away on the same frame it would reach an edge prevents the goal, because direction is resolved before the edge check.
  - Corner (x and y limits on the same upd): both wall rules apply independently; a goal takes priority over the x clamp.
  - start is ignored in SERVE and MOVE.
  - bounce flags are ignored outside MOVE.
  - frame_tick held high continuously produces exactly one upd.
  - reset asserted mid-frame returns everything to reset values immediately; no partial update survives.
  - winner stays at the last scorer across SERVE until the next goal or a match restart.

Test Plan:
- Reset, start=1, 60 frame edges → in_play rises on the 60th upd. Next upd → ball_x=322, ball_y=241.
- From MOVE at (322, 460) moving down, 4 upd → ball_y clamps at 464, then dir_y=up. Following upd → ball_y=463.
- Force ball toward left with ball_y=240, reaching X_MIN → goal_pulse 1 cycle, p2_score=1, winner=2, ball=(320,240), state SERVE, later serve dir_x=left.
- Same approach with ball_y=100 → no goal; ball_x=10, dir_x flips right, scores unchanged.
- bounce_x=1 on the upd where nx would be ≤ 10 → ball moves right by 2, no goal_pulse.
- p1 at 6, scores again → p1_score=7, winner=1, state OVER. Further frame edges keep the ball at centre. start → scores 0, winner 0, SERVE. reset=0 mid-MOVE → immediate centre and zero scores.
